pulse_pattern_gen: RTL
======================

PULSE_PATTERN_GEN -- requirements
Module: pulse_pattern_gen

Interface
REQ-001 Parameter SHORT_CYC, default 2: DOUT high width, in CLK cycles, of a short symbol.
REQ-002 Parameter LONG_CYC, default 6: DOUT high width, in CLK cycles, of a long symbol.
REQ-003 Parameter GAP_CYC, default 4: DOUT low width, in CLK cycles, after every symbol.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high. Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous active-high reset.
- START  in  1  request to send a pattern; sampled only in IDLE.
- PATTERN  in  8  symbol bits; 1=long, 0=short; bit 0 is sent first.
- LEN  in  4  number of symbols to send, 0..15.
- DOUT  out  1  registered serial pulse output.
- BUSY  out  1  high while a pattern is being emitted.
- DONE  out  1  one-cycle completion strobe.

Function
REQ-005 The FSM SHALL have four states: IDLE, HIGH, LOW and FIN.
REQ-006 In IDLE, START=1 with LEN!=0 SHALL latch PATTERN and min(LEN,8) into internal registers and go to HIGH.
- LEN values 9..15 SHALL be clamped to 8.
REQ-007 In IDLE, START=1 with LEN=0 SHALL go directly to FIN: no DOUT activity, and DONE=1 on the next cycle.
REQ-008 DOUT SHALL be 1 exactly while in HIGH.
- Dwell in HIGH is LONG_CYC cycles if the current symbol bit is 1, otherwise SHORT_CYC cycles.
REQ-009 Leaving HIGH SHALL enter LOW, where DOUT=0 for exactly GAP_CYC cycles.
REQ-010 At the end of LOW:
- If symbols remain, the block SHALL shift the latched pattern right by one and return to HIGH.
- Otherwise it SHALL go to FIN.
REQ-011 FIN SHALL last exactly one cycle with DONE=1 and BUSY=0, then go to IDLE.
REQ-012 BUSY SHALL be 1 exactly in HIGH and LOW.
REQ-013 The first DOUT=1 cycle SHALL be the cycle immediately after the edge that accepts START; latency is 1 cycle.
REQ-014 Total BUSY duration SHALL equal sum over sent symbols of (width + GAP_CYC).
REQ-015 START SHALL be ignored in HIGH, LOW and FIN. Changes to PATTERN or LEN after acceptance SHALL NOT affect the pattern in flight.
REQ-016 START held high continuously SHALL cause back-to-back patterns, separated by exactly one FIN cycle and then the accepting IDLE cycle.
REQ-017 The dwell counter SHALL be a down-counter sized ceil(log2(max(SHORT_CYC,LONG_CYC,GAP_CYC)+1)) bits. Every parameter SHALL be >=1; elaboration SHALL fail on 0.
REQ-018 LONG_CYC > SHORT_CYC SHALL be checked at elaboration.

Reset
REQ-019 RST=1 at a rising edge SHALL force IDLE and clear the counters and latched registers. Outputs SHALL be DOUT=0, BUSY=0 and DONE=0 from the next cycle.
REQ-020 RST asserted mid-pattern SHALL abort immediately, with no DONE strobe. A START sampled in the same cycle as RST SHALL be discarded.
REQ-021 All outputs SHALL be driven from registers; no combinational path from inputs to outputs.

Structure
REQ-022 Package pattern_pkg SHALL hold:
- the state enumeration (IDLE, HIGH, LOW, FIN);
- default constants SHORT_CYC_DEF=2, LONG_CYC_DEF=6, GAP_CYC_DEF=4;
- MAX_SYMBOLS=8.
REQ-023 One sub-module, pulse_timer, SHALL be used. It is the loadable down-counter with inputs load and value, and output expire.

Verification (defaults SHORT=2, LONG=6, GAP=4; START accepted at edge k)
REQ-024 Mixed pattern: PATTERN=8'b00000001, LEN=2 -> DOUT=1 k+1..k+6, 0 k+7..k+10, 1 k+11..k+12, 0 k+13..k+16; DONE=1 only at k+17; BUSY=1 k+1..k+16.
REQ-025 Empty pattern: LEN=0 -> DOUT stays 0, BUSY stays 0, DONE=1 at k+1 only.
REQ-026 Clamp: LEN=15, PATTERN=8'hFF -> exactly 8 long pulses; BUSY for 80 cycles; DONE at k+81.
REQ-027 Busy input changes: PATTERN changed and START re-pulsed during HIGH -> output matches the originally latched pattern; no second run.
REQ-028 Mid-pattern reset: RST=1 at k+3 -> DOUT=0 and BUSY=0 from k+4; no DONE; a new START afterwards runs normally.
REQ-029 Loopback: chain output into the pulse-width classifier on DIN -> one DOUT_SHORT or DOUT_LONG indication per symbol, in PATTERN bit order.

Source files
------------

// File: rtl/pattern_pkg.sv
// -----------------------------------------------------------------------------
// pattern_pkg
// Shared definitions for the pulse pattern generator:
//   - state_t      : FSM state enumeration (IDLE, HIGH, LOW, FIN)
//   - *_CYC_DEF    : default symbol/gap widths in clock cycles
//   - MAX_SYMBOLS  : largest number of symbols one pattern can carry
//   - clamp_len()  : limits a requested symbol count to MAX_SYMBOLS
//   - max3()       : largest of three ints, used to size the dwell counter
// -----------------------------------------------------------------------------
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int SHORT_CYC_DEF = 2;
  localparam int LONG_CYC_DEF  = 6;
  localparam int GAP_CYC_DEF   = 4;
  localparam int MAX_SYMBOLS   = 8;

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    return (len > 4'(MAX_SYMBOLS)) ? 4'(MAX_SYMBOLS) : len;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// -----------------------------------------------------------------------------
// pulse_timer
// Loadable down-counter that times each dwell of the pattern generator.
// Loading N makes expire rise N cycles later, so loading (width-1) gives a
// dwell of exactly width cycles. Once the count reaches zero it holds there.
// Ports:
//   clk    in  rising-edge clock
//   rst    in  synchronous active-high reset (clears the count)
//   load   in  load value into the counter this edge
//   value  in  W-bit load value
//   expire out high while the count is zero (last cycle of a dwell)
// -----------------------------------------------------------------------------
module pulse_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] count;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/pulse_pattern_gen.sv
// -----------------------------------------------------------------------------
// pulse_pattern_gen
// Serialises up to 8 symbols as pulses on DOUT: a '1' symbol is a LONG_CYC
// high pulse, a '0' symbol a SHORT_CYC high pulse, each followed by GAP_CYC
// low cycles. Bit 0 of PATTERN is sent first. A one-cycle DONE strobe marks
// the end of every accepted request (including an empty LEN=0 request).
// Ports:
//   CLK     in  rising-edge clock
//   RST     in  synchronous active-high reset
//   START   in  start request, only sampled in IDLE
//   PATTERN in  8 symbol bits (1=long, 0=short)
//   LEN     in  symbol count 0..15, clamped to 8
//   DOUT    out registered pulse output
//   BUSY    out high while symbols are being emitted
//   DONE    out one-cycle completion strobe
// -----------------------------------------------------------------------------
module pulse_pattern_gen
  import pattern_pkg::*;
#(
  parameter int SHORT_CYC = SHORT_CYC_DEF,
  parameter int LONG_CYC  = LONG_CYC_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] PATTERN,
  input  logic [3:0] LEN,
  output logic       DOUT,
  output logic       BUSY,
  output logic       DONE
);

  localparam int CW = $clog2(max3(SHORT_CYC, LONG_CYC, GAP_CYC) + 1);

  // Timer load values are one less than the dwell length.
  localparam logic [CW-1:0] SHORT_LD = CW'(SHORT_CYC - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);

  if (SHORT_CYC < 1 || LONG_CYC < 1 || GAP_CYC < 1) begin : g_bad_zero
    $error("pulse_pattern_gen: SHORT_CYC, LONG_CYC and GAP_CYC must all be >= 1");
  end
  if (LONG_CYC <= SHORT_CYC) begin : g_bad_order
    $error("pulse_pattern_gen: LONG_CYC must be greater than SHORT_CYC");
  end

  state_t          state;
  logic [7:0]      pat;        // latched pattern, current symbol in bit 0
  logic [3:0]      remaining;  // symbols left, including the current one
  logic            load;
  logic [CW-1:0]   value;
  logic            expire;

  pulse_timer #(.W(CW)) u_timer (
    .clk    (CLK),
    .rst    (RST),
    .load   (load),
    .value  (value),
    .expire (expire)
  );

  // Timer reload is decided alongside the state transition so the new dwell
  // starts counting on the same edge the FSM enters HIGH or LOW.
  // NOTE: every signal written here gets a default first; otherwise paths that
  // skip an assignment would infer a latch.
  always_comb begin
    load  = 1'b0;
    value = '0;
    case (state)
      IDLE: if (START && LEN != '0) begin
        load  = 1'b1;
        value = PATTERN[0] ? LONG_LD : SHORT_LD;
      end
      HIGH: if (expire) begin
        load  = 1'b1;
        value = GAP_LD;
      end
      LOW: if (expire && remaining > 4'd1) begin
        load  = 1'b1;
        value = pat[1] ? LONG_LD : SHORT_LD;
      end
      default: ;
    endcase
  end

  // NOTE: all control registers, including the latched pattern, are reset so
  // an aborted pattern leaves nothing behind for the next request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      pat       <= '0;
      remaining <= '0;
      DOUT      <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            if (LEN != '0) begin
              pat       <= PATTERN;
              remaining <= clamp_len(LEN);
              state     <= HIGH;
              DOUT      <= 1'b1;
              BUSY      <= 1'b1;
            end else begin
              state <= FIN;
              DONE  <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (expire) begin
            state <= LOW;
            DOUT  <= 1'b0;
          end
        end
        LOW: begin
          if (expire) begin
            if (remaining > 4'd1) begin
              remaining <= remaining - 4'd1;
              pat       <= pat >> 1;
              state     <= HIGH;
              DOUT      <= 1'b1;
            end else begin
              state <= FIN;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
